muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for the M-extension ops (MUL, DIV, REM) in the EX stage.

---
 rtl/md_pkg.sv | 10 +
 rtl/md_addsub.sv | 11 +
 rtl/muldiv_seq.sv | 79 +++++++
 tb/tb_muldiv_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared ALU op codes and sequencer state encoding for the M-extension engine
package md_pkg;
  localparam logic [3:0] ALU_MUL = 4'b1001;
  localparam logic [3:0] ALU_DIV = 4'b1010;
  localparam logic [3:0] ALU_REM = 4'b1011;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} md_state_t;
  function automatic logic is_md_op(input logic [3:0] op);
    return op == ALU_MUL || op == ALU_DIV || op == ALU_REM;
  endfunction
endpackage

// File: rtl/md_addsub.sv
// md_addsub: W-bit adder/subtractor shared by the shift-add and restoring-divide iterations
module md_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);
  assign sum = x + (y ^ {W{sub}}) + W'(sub);
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MUL/DIV/REM sequencer that stalls the pipeline until its result is ready
module muldiv_seq
  import md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);
  md_state_t state, state_nxt;
  logic [3:0] op;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] acc, x_q, y_q, rem, res_q, fin;
  logic [XLEN:0] rem_sh, add_a, sum;
  logic go, dz, is_mul, ld_mul;
  assign go = start && is_md_op(alu_op) && !flush;
  assign dz = alu_op != ALU_MUL && b == '0;
  assign ld_mul = alu_op == ALU_MUL;
  assign is_mul = op == ALU_MUL;
  // x_q holds multiplicand or divisor; y_q holds multiplier or dividend shifting into quotient
  assign rem_sh = {rem, y_q[XLEN-1]};
  assign add_a = is_mul ? {1'b0, acc} : rem_sh;
  md_addsub #(.W(XLEN + 1)) u_addsub (
    .x   (add_a),
    .y   ({1'b0, x_q}),
    .sub (!is_mul),
    .sum (sum)
  );
  assign fin = is_mul ? acc : op == ALU_DIV ? y_q : rem;
  // A flush in DONE keeps the previous result visible
  assign result = done ? fin : res_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (go ? (dz ? DONE : CALC) : IDLE) :
                state == CALC ? (flush ? IDLE : cnt == CNT_W'(XLEN - 1) ? DONE : CALC) : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    stall_req = (state == IDLE && start && is_md_op(alu_op)) || state == CALC;
    done = state == DONE && !flush;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op <= '0;
      cnt <= '0;
      acc <= '0;
      x_q <= '0;
      y_q <= '0;
      rem <= '0;
      res_q <= '0;
    end else if (state == IDLE && go) begin
      op <= alu_op;
      cnt <= '0;
      acc <= '0;
      x_q <= ld_mul ? a : b;
      y_q <= ld_mul ? b : dz ? '1 : a;
      rem <= dz ? a : '0;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= is_mul && y_q[0] ? sum[XLEN-1:0] : acc;
      x_q <= is_mul ? x_q << 1 : x_q;
      y_q <= is_mul ? y_q >> 1 : {y_q[XLEN-2:0], !sum[XLEN]};
      rem <= is_mul ? rem : sum[XLEN] ? rem_sh[XLEN-1:0] : sum[XLEN-1:0];
    end else if (done) begin
      res_q <= fin;
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq against a plain-arithmetic reference
module tb_muldiv_seq;
  localparam logic [3:0] MUL = 4'b1001, DIV = 4'b1010, REM = 4'b1011, ADD = 4'b0000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [3:0] alu_op = ADD;
  logic [31:0] a = '0, b = '0;
  logic busy, stall_req, done;
  logic [31:0] result, last;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] ops [3] = '{MUL, DIV, REM};

  muldiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op == MUL) return x * y;
    if (op == DIV) return y == 0 ? 32'hFFFF_FFFF : x / y;
    return y == 0 ? x : x % y;
  endfunction

  task automatic run(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    int lat;
    er = ref_res(op, x, y);
    lat = (op != MUL && y == 0) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; alu_op = op; a = x; b = y;
    #1 chk("stall_c0", 32'(stall_req), 1);
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      chk("done", 32'(done), 32'(n == lat));
      if (n < lat) chk("stall", 32'(stall_req), 1);
    end
    chk("stall_done", 32'(stall_req), 0);
    chk("result", result, er);
    last = er;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", result, 0);
    @(negedge clk) rst = 1'b0;
    run(MUL, 7, 6);
    run(MUL, 32'hFFFF_FFFF, 2);
    run(DIV, 100, 7);
    run(REM, 100, 7);
    run(DIV, 5, 0);
    run(REM, 5, 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    // flush partway through a divide
    start = 1'b1; alu_op = DIV; a = 1000; b = 3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_done", 32'(done), 0);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_result", result, 5);
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      chk("flush_nodone", 32'(done), 0);
    end
    run(DIV, 1000, 3);
    // flush wins over a simultaneous start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; alu_op = MUL; a = 3; b = 4;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("flush_prio", 32'(busy), 0);
    // flush landing in the DONE cycle
    @(negedge clk);
    start = 1'b1; alu_op = DIV; a = 9; b = 0;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b1;
    #1 chk("fdone_done", 32'(done), 0);
    chk("fdone_res", result, last);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("fdone_busy", 32'(busy), 0);
    chk("fdone_res2", result, last);
    // asynchronous reset mid-calculation
    @(negedge clk);
    start = 1'b1; alu_op = MUL; a = 123; b = 456;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 chk("calc_busy", 32'(busy), 1);
    rst = 1'b1;
    #1 chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_result", result, 0);
    @(negedge clk) rst = 1'b0;
    // non-M op is ignored
    @(negedge clk);
    start = 1'b1; alu_op = ADD; a = 1; b = 2;
    #1 chk("add_stall", 32'(stall_req), 0);
    @(posedge clk);
    #1 start = 1'b0;
    chk("add_busy", 32'(busy), 0);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = (i % 4 == 0) ? 0 : (i % 4 == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      run(ops[$urandom_range(0, 2)], x, y);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
